// File: rtl/cpu_pkg.sv
// Shared CPU types for the EX-stage divider: operation and FSM state enums,
// plus the alu_rd_operator encodings that select a divide operation.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam logic [3:0] ALU_RD_DIV  = 4'hC;
  localparam logic [3:0] ALU_RD_DIVU = 4'hD;
  localparam logic [3:0] ALU_RD_REM  = 4'hE;
  localparam logic [3:0] ALU_RD_REMU = 4'hF;

  function automatic logic alu_rd_is_div(input logic [3:0] alu_rd_operator);
    return (alu_rd_operator == ALU_RD_DIV)  || (alu_rd_operator == ALU_RD_DIVU) ||
           (alu_rd_operator == ALU_RD_REM)  || (alu_rd_operator == ALU_RD_REMU);
  endfunction

  function automatic div_op_t alu_rd_to_div_op(input logic [3:0] alu_rd_operator);
    case (alu_rd_operator)
      ALU_RD_DIVU: return OP_DIVU;
      ALU_RD_REM:  return OP_REM;
      ALU_RD_REMU: return OP_REMU;
      default:     return OP_DIV;
    endcase
  endfunction

  function automatic logic op_is_signed(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_iterative_divider_if.sv
// Request/response bundle between the ID/EX stage and the iterative divider.
// start is accepted only while the divider is idle; done pulses for one cycle with result.
interface ex_iterative_divider_if
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
);
  logic             start;
  div_op_t          op;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  div_state_t       state;

  modport master (
    output start, op, dividend, divisor, flush,
    input  stall, busy, done, result, state
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output stall, busy, done, result, state
  );
endinterface

// File: rtl/ex_iterative_divider_clz_counter.sv
// Combinational leading-zero count; an all-zero input returns XLEN.
// Only instantiated when DIV_EARLY_OUT_EN is defined.
module clz_counter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          val_i,
  output logic [$clog2(XLEN):0]    cnt_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic found;

  always_comb begin
    cnt_o = CW'(XLEN);
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!found && val_i[i]) begin
        cnt_o = CW'(XLEN - 1 - i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ex_iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU: radix-2 restoring divider, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN skips the dividend's leading zeros at acceptance.
module ex_iterative_divider
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  ex_iterative_divider_if.slave   div_if
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  result_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             is_rem_q;
  logic             done_q;

  logic             in_signed;
  logic             in_rem;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  init_quo;
  logic [CW-1:0]    init_cnt;

  always_comb begin
    in_signed   = op_is_signed(div_if.op);
    in_rem      = op_is_rem(div_if.op);
    a_neg       = in_signed & div_if.dividend[XLEN-1];
    b_neg       = in_signed & div_if.divisor[XLEN-1];
    a_mag       = a_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
    b_mag       = b_neg ? (~div_if.divisor + 1'b1) : div_if.divisor;
    special     = 1'b1;
    special_res = '0;
    // Cases the iteration cannot produce correctly resolve in a single cycle.
    if (div_if.divisor == '0) begin
      special_res = in_rem ? div_if.dividend : '1;
    end else if (in_signed && (div_if.dividend == MIN_NEG) && (div_if.divisor == '1)) begin
      special_res = in_rem ? '0 : div_if.dividend;
`ifdef DIV_EARLY_OUT_EN
    end else if (a_mag == '0) begin
      special_res = '0;
`endif
    end else begin
      special = 1'b0;
    end
  end

`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0] a_clz;

  clz_counter #(.XLEN(XLEN)) u_clz (
    .val_i (a_mag),
    .cnt_o (a_clz)
  );

  // Leading zeros would only shift in zero quotient bits, so skip them.
  assign init_quo = a_mag << a_clz;
  assign init_cnt = CW'(XLEN) - a_clz;
`else
  assign init_quo = a_mag;
  assign init_cnt = CW'(XLEN);
`endif

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             q_bit;
  logic [XLEN-1:0]  rem_d;
  logic [XLEN-1:0]  quo_d;
  logic [XLEN-1:0]  fin_d;

  // quo_q holds the unconsumed dividend bits at the top and the quotient at the bottom.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign q_bit   = ~diff[XLEN];
  assign rem_d   = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_d   = {quo_q[XLEN-2:0], q_bit};
  assign fin_d   = is_rem_q ? (neg_rem_q ? (~rem_d + 1'b1) : rem_d)
                            : (neg_quo_q ? (~quo_d + 1'b1) : quo_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (div_if.flush) begin
        state_q <= DIV_IDLE;
      end else begin
        case (state_q)
          DIV_IDLE: begin
            if (div_if.start) begin
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              is_rem_q  <= in_rem;
              if (special) begin
                result_q <= special_res;
                done_q   <= 1'b1;
                state_q  <= DIV_DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= init_quo;
                dvs_q   <= b_mag;
                cnt_q   <= init_cnt;
                state_q <= DIV_BUSY;
              end
            end
          end
          DIV_BUSY: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              result_q <= fin_d;
              done_q   <= 1'b1;
              state_q  <= DIV_DONE;
            end
          end
          DIV_DONE: state_q <= DIV_IDLE;
          default:  state_q <= DIV_IDLE;
        endcase
      end
    end
  end

  // Combinational so the pipeline is held from the very cycle the divide is offered.
  assign div_if.stall  = ((state_q == DIV_IDLE) & div_if.start & ~div_if.flush) |
                         (state_q == DIV_BUSY);
  assign div_if.busy   = (state_q == DIV_BUSY);
  assign div_if.done   = done_q;
  assign div_if.result = result_q;
  assign div_if.state  = state_q;

endmodule

// File: tb/tb_ex_iterative_divider.sv
// Self-checking bench for ex_iterative_divider: vector table plus hand-built
// sequences for flush, back-to-back issue and asynchronous reset.
module tb_ex_iterative_divider;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  ex_iterative_divider_if #(.XLEN(32)) dif ();

  ex_iterative_divider #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    div_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      default: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
    endcase
  endfunction

  function automatic int ref_lat(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [31:0] mag;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 0) return 1;
    if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    mag = (sgn && a[31]) ? (~a + 32'd1) : a;
`ifdef DIV_EARLY_OUT_EN
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) return i + 2;
    end
    return 1;
`else
    if (mag == 0) return 33;
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow actual=done expected=no_done");
      return 32'hDEAD_BEEF;
    end
    return exp_q.pop_front();
  endfunction

  task automatic do_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
    int   lat;
    int   cyc;
    int   stall_hi;
    logic got;
    lat = ref_lat(op, a, b);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.op = op; dif.dividend = a; dif.divisor = b;
    exp_q.push_back(exp);
    @(negedge clk);
    check({name, "_stall_c0"}, {31'b0, dif.stall}, 32'd1);
    @(posedge clk); #1;
    dif.start    = 1'b0;
    dif.op       = div_op_t'($urandom_range(0, 3));
    dif.dividend = $urandom;
    dif.divisor  = $urandom;
    cyc = 1; stall_hi = 0; got = 1'b0;
    while (!got && cyc <= 100) begin
      @(negedge clk);
      if (dif.done) begin
        got = 1'b1;
        check({name, "_latency"}, cyc, lat);
        check({name, "_result"}, dif.result, pop_exp());
        check({name, "_stall_cycles"}, stall_hi, lat - 1);
      end else begin
        if (dif.stall) stall_hi++;
        cyc++;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout actual=no_done expected=done_by_cycle_%0d", name, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int lat1, lat2, acc, n_done, d1, d2, done_seen;
    logic [31:0] prev;

    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    dif.start = 1'b0; dif.op = OP_DIV; dif.dividend = '0; dif.divisor = '0; dif.flush = 1'b0;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          "rem_7_m2"};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  "div_5_0"};
    vecs[6]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          "remu_5_0"};
    vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"};
    vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf"};
    vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  "divu_max_1"};
    vecs[10] = '{OP_DIVU, 32'd3,          32'd1,          32'd3,          "divu_3_1"};
    vecs[11] = '{OP_DIV,  32'd0,          32'd5,          32'd0,          "div_0_5"};
    vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "divu_big"};
    vecs[13] = '{OP_REMU, 32'd7,          32'hFFFF_FFFF,  32'd7,          "remu_7_max"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'b0, dif.busy},  32'd0);
    check("rst_done",   {31'b0, dif.done},  32'd0);
    check("rst_stall",  {31'b0, dif.stall}, 32'd0);
    check("rst_result", dif.result,         32'd0);
    check("rst_state",  {30'b0, dif.state}, {30'b0, DIV_IDLE});
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    for (int i = 0; i < 8; i++) begin
      div_op_t     rop;
      logic [31:0] ra, rb;
      rop = div_op_t'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      do_op(rop, ra, rb, ref_div(rop, ra, rb), "rand");
    end

    // Back-to-back: start held high throughout, so the second op is taken
    // the cycle after DONE with whatever operands are present then.
    lat1 = ref_lat(OP_DIVU, 32'd1000, 32'd10);
    lat2 = ref_lat(OP_DIVU, 32'd50000, 32'd7);
    acc  = lat1 + 1;
    @(posedge clk); #1;
    dif.start = 1'b1; dif.op = OP_DIVU; dif.dividend = 32'd1000; dif.divisor = 32'd10;
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd7142);
    @(posedge clk); #1;
    dif.dividend = 32'd50000; dif.divisor = 32'd7;
    n_done = 0; d1 = -1; d2 = -1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (dif.done) begin
        n_done++;
        if (n_done == 1) d1 = cyc; else d2 = cyc;
        check("b2b_result", dif.result, pop_exp());
      end
      if (cyc == acc) check("b2b_accept_stall", {31'b0, dif.stall}, 32'd1);
      @(posedge clk); #1;
      if (cyc == acc) dif.start = 1'b0;
    end
    dif.start = 1'b0;
    check("b2b_done_count", n_done, 32'd2);
    check("b2b_first_done", d1, lat1);
    check("b2b_second_done", d2, acc + lat2);
    while (exp_q.size() > 0) void'(exp_q.pop_front());

    // Flush in cycle 10 of a running divide.
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, "pre_flush");
    prev = 32'd14;
    @(posedge clk); #1;
    dif.start = 1'b1; dif.op = OP_DIVU; dif.dividend = 32'd12345; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    dif.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {31'b0, dif.busy}, 32'd1);
    @(posedge clk); #1;
    dif.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   {31'b0, dif.busy},  32'd0);
    check("flush_stall",  {31'b0, dif.stall}, 32'd0);
    check("flush_done",   {31'b0, dif.done},  32'd0);
    check("flush_result", dif.result,         prev);
    check("flush_state",  {30'b0, dif.state}, {30'b0, DIV_IDLE});
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.done) done_seen++;
    end
    check("flush_no_done", done_seen, 32'd0);
    do_op(OP_DIVU, 32'd12345, 32'd3, 32'd4115, "post_flush");

    // Asynchronous reset between clock edges while busy.
    @(posedge clk); #1;
    dif.start = 1'b1; dif.op = OP_DIVU; dif.dividend = 32'hFFFF_0000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("areset_busy_before", {31'b0, dif.busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy",   {31'b0, dif.busy},  32'd0);
    check("areset_stall",  {31'b0, dif.stall}, 32'd0);
    check("areset_done",   {31'b0, dif.done},  32'd0);
    check("areset_result", dif.result,         32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
